sudoku_draw_cell: RTL and testbench

// - Rasterises one 9x9 Sudoku board cell into the frame-buffer write path.
// - On a start request, it latches the cell row, column and digit.
// - It then emits one pixel per clock, each as an absolute screen position plus a 3-bit colour code.
// - It sits between the board controller (issues start_write) and the frame-buffer writer (consumes position/colour while working=1).

---
 rtl/sudoku_draw_cell_pkg.sv | 17 +
 rtl/sudoku_draw_cell_digit_font_rom.sv | 23 ++
 rtl/sudoku_draw_cell.sv | 66 ++++++
 tb/tb_sudoku_draw_cell.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sudoku_draw_cell_pkg.sv
// screen: shared screen geometry, pixel position type, colour codes and draw FSM states
package screen;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } position;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  localparam logic [2:0] COLOR_BG = 3'd0;
  localparam logic [2:0] COLOR_DIGIT = 3'd1;
  localparam logic [2:0] COLOR_BORDER = 3'd2;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CELL_SIZE = 48;
  localparam int GRID_X0 = 104;
  localparam int GRID_Y0 = 24;
  localparam logic [5:0] LAST = 6'(CELL_SIZE - 1);
endpackage

// File: rtl/sudoku_draw_cell_digit_font_rom.sv
// digit_font_rom: 8x8 glyphs for digits 1..9, top row in the high byte, bit 0 is the leftmost column
module digit_font_rom (
  input  logic [3:0] digit,
  input  logic [2:0] glyph_row,
  output logic [7:0] row_bits
);
  logic [63:0] glyph;
  always_comb begin
    case (digit)
      4'd1: glyph = 64'h0C0E0C0C0C0C3F00;
      4'd2: glyph = 64'h1E33301C06333F00;
      4'd3: glyph = 64'h1E33301C30331E00;
      4'd4: glyph = 64'h383C36337F307800;
      4'd5: glyph = 64'h3F031F3030331E00;
      4'd6: glyph = 64'h1C06031F33331E00;
      4'd7: glyph = 64'h3F3330180C0C0C00;
      4'd8: glyph = 64'h1E33331E33331E00;
      4'd9: glyph = 64'h1E33333E30180E00;
      default: glyph = '0;
    endcase
    row_bits = glyph[{~glyph_row, 3'b000} +: 8];
  end
endmodule

// File: rtl/sudoku_draw_cell.sv
// sudoku_draw_cell: rasterises one board cell (border plus 4x-scaled digit glyph), one pixel per clock
module sudoku_draw_cell import screen::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_write,
  input  logic [3:0] cell_row,
  input  logic [3:0] cell_col,
  input  logic [3:0] cell_data,
  output logic       working,
  output position    absolute_position,
  output logic [2:0] color_code
);
  state_t state, state_n;
  logic [5:0] px, py;
  logic [3:0] row, col, data;
  logic [7:0] row_bits;
  logic [2:0] glyph_col, colour;
  logic [9:0] nx;
  logic [8:0] ny;
  logic accept, last, border, window;
  digit_font_rom rom (.digit(data), .glyph_row(py[4:2] - 3'd2), .row_bits(row_bits));
  always_comb begin
    accept = start_write && cell_row <= 4'd8 && cell_col <= 4'd8;
    last = px == LAST && py == LAST;
    state_n = state == IDLE ? (accept ? DRAW : IDLE) :
              state == DRAW ? (last ? DONE : DRAW) :
              (start_write ? DONE : IDLE);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // 48*n computed as (n<<5)+(n<<4); glyph offsets use mod-8 arithmetic on px/py>>2
  always_comb begin
    nx = 10'(GRID_X0) + {1'b0, col, 5'b0} + {2'b0, col, 4'b0} + {4'b0, px};
    ny = 9'(GRID_Y0) + {row, 5'b0} + {1'b0, row, 4'b0} + {3'b0, py};
    border = px == 6'd0 || py == 6'd0 || px == LAST || py == LAST;
    window = px >= 6'd8 && px <= 6'd39 && py >= 6'd8 && py <= 6'd39;
    glyph_col = px[4:2] - 3'd2;
    colour = border ? COLOR_BORDER : (window && row_bits[glyph_col]) ? COLOR_DIGIT : COLOR_BG;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      working <= 1'b0;
      absolute_position <= '0;
      color_code <= COLOR_BG;
      px <= '0;
      py <= '0;
      row <= '0;
      col <= '0;
      data <= '0;
    end else begin
      working <= state == DRAW;
      if (state == IDLE && accept) begin
        row <= cell_row;
        col <= cell_col;
        data <= cell_data;
        px <= '0;
        py <= '0;
      end
      if (state == DRAW) begin
        absolute_position <= '{x: nx, y: ny};
        color_code <= colour;
        px <= px == LAST ? 6'd0 : px + 6'd1;
        py <= px == LAST ? py + 6'd1 : py;
      end
    end
  end
endmodule

// File: tb/tb_sudoku_draw_cell.sv
// tb_sudoku_draw_cell: randomized draws checked against a per-pixel model of the cell rendering rules
module tb_sudoku_draw_cell;
  logic clk = 0, reset = 1, start_write = 0;
  logic [3:0] cell_row = 0, cell_col = 0, cell_data = 0;
  logic working;
  logic [18:0] absolute_position;
  logic [2:0] color_code;
  int errors = 0, checks = 0;
  logic [7:0] font [10][8] = '{
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h0C, 8'h0E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h3F, 8'h00},
    '{8'h1E, 8'h33, 8'h30, 8'h1C, 8'h06, 8'h33, 8'h3F, 8'h00},
    '{8'h1E, 8'h33, 8'h30, 8'h1C, 8'h30, 8'h33, 8'h1E, 8'h00},
    '{8'h38, 8'h3C, 8'h36, 8'h33, 8'h7F, 8'h30, 8'h78, 8'h00},
    '{8'h3F, 8'h03, 8'h1F, 8'h30, 8'h30, 8'h33, 8'h1E, 8'h00},
    '{8'h1C, 8'h06, 8'h03, 8'h1F, 8'h33, 8'h33, 8'h1E, 8'h00},
    '{8'h3F, 8'h33, 8'h30, 8'h18, 8'h0C, 8'h0C, 8'h0C, 8'h00},
    '{8'h1E, 8'h33, 8'h33, 8'h1E, 8'h33, 8'h33, 8'h1E, 8'h00},
    '{8'h1E, 8'h33, 8'h33, 8'h3E, 8'h30, 8'h18, 8'h0E, 8'h00}};
  always #5 clk = ~clk;
  sudoku_draw_cell dut (
    .clk(clk), .reset(reset), .start_write(start_write), .cell_row(cell_row),
    .cell_col(cell_col), .cell_data(cell_data), .working(working),
    .absolute_position(absolute_position), .color_code(color_code));
  function automatic int model_color(int d, int px, int py);
    if (px == 0 || py == 0 || px == 47 || py == 47) return 2;
    if (px >= 8 && px < 40 && py >= 8 && py < 40 && d >= 1 && d <= 9 && font[d][(py - 8) / 4][(px - 8) / 4]) return 1;
    return 0;
  endfunction
  task automatic draw_check(input int r, c, d, hold, input bit scramble, output int fx, fy, lx, ly, ones);
    int bad, hi, t, ex, ey, ec, first, exp_ones, late;
    bad = 0; hi = 0; t = 0; first = -1; ones = 0; exp_ones = 0; late = 0;
    fx = 0; fy = 0; lx = 0; ly = 0;
    cell_row = 4'(r); cell_col = 4'(c); cell_data = 4'(d); start_write = 1;
    @(negedge clk); t++; if (t >= hold) start_write = 0;
    checks++;
    if (working !== 1'b0) begin errors++; $display("FAIL latency_accept: working=%b expected 0", working); end
    @(negedge clk); t++; if (t >= hold) start_write = 0;
    checks++;
    if (working !== 1'b1) begin errors++; $display("FAIL latency_rise: working=%b expected 1", working); end
    for (int i = 0; i < 2304; i++) begin
      ex = 104 + c * 48 + i % 48;
      ey = 24 + r * 48 + i / 48;
      ec = model_color(d, i % 48, i / 48);
      if (ec == 1) exp_ones++;
      if (working === 1'b1) hi++;
      if (color_code === 3'd1) ones++;
      if (absolute_position[18:9] !== 10'(ex) || absolute_position[8:0] !== 9'(ey) || color_code !== 3'(ec)) begin
        if (bad == 0) first = i;
        bad++;
      end
      if (i == 0) begin fx = int'(absolute_position[18:9]); fy = int'(absolute_position[8:0]); end
      if (i == 2303) begin lx = int'(absolute_position[18:9]); ly = int'(absolute_position[8:0]); end
      if (scramble && i == 700) begin
        cell_row = 4'($urandom_range(0, 15)); cell_col = 4'($urandom_range(0, 15)); cell_data = 4'($urandom_range(0, 15));
      end
      @(negedge clk); t++; if (t >= hold) start_write = 0;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pixels r=%0d c=%0d d=%0d: %0d bad pixels, first at %0d, expected 0 bad", r, c, d, bad, first); end
    checks++;
    if (hi != 2304) begin errors++; $display("FAIL working_high: %0d cycles expected 2304", hi); end
    checks++;
    if (working !== 1'b0) begin errors++; $display("FAIL working_fall: working=%b expected 0", working); end
    checks++;
    if (ones != exp_ones) begin errors++; $display("FAIL digit_pixels d=%0d: %0d expected %0d", d, ones, exp_ones); end
    if (start_write) begin
      repeat (10) begin @(negedge clk); if (working !== 1'b0) late++; end
      checks++;
      if (late != 0) begin errors++; $display("FAIL retrigger: working high %0d cycles expected 0", late); end
      start_write = 0;
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1; start_write = 1; cell_row = 1; cell_col = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (working !== 1'b0) begin errors++; $display("FAIL reset_dominates: working=%b expected 0", working); end
    start_write = 0; reset = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (working !== 1'b0 || absolute_position !== 19'd0 || color_code !== 3'd0)
      begin errors++; $display("FAIL reset_state: working=%b pos=%h colour=%0d expected 0 0 0", working, absolute_position, color_code); end
  endtask
  task automatic test_start();
    int fx, fy, lx, ly, ones;
    draw_check(0, 0, 0, 5, 0, fx, fy, lx, ly, ones);
    checks++;
    if (fx != 104 || fy != 24 || lx != 151 || ly != 71)
      begin errors++; $display("FAIL start_corners: (%0d,%0d)-(%0d,%0d) expected (104,24)-(151,71)", fx, fy, lx, ly); end
  endtask
  task automatic test_corner();
    int fx, fy, lx, ly, ones;
    draw_check(8, 8, 5, 5, 1, fx, fy, lx, ly, ones);
    checks++;
    if (fx != 488 || fy != 408 || lx != 535 || ly != 455)
      begin errors++; $display("FAIL corner_positions: (%0d,%0d)-(%0d,%0d) expected (488,408)-(535,455)", fx, fy, lx, ly); end
  endtask
  task automatic test_sweep();
    int fx, fy, lx, ly, ones;
    for (int d = 0; d < 9; d++) begin
      draw_check($urandom_range(0, 8), $urandom_range(0, 8), d, 5, 0, fx, fy, lx, ly, ones);
      if (d == 0) begin
        checks++;
        if (ones != 0) begin errors++; $display("FAIL empty_cell: %0d digit pixels expected 0", ones); end
      end
      repeat (5) @(negedge clk);
    end
    draw_check($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(10, 15), 5, 1, fx, fy, lx, ly, ones);
  endtask
  task automatic test_back_to_back();
    int fx, fy, lx, ly, ones;
    draw_check(4, 2, 9, 100000, 0, fx, fy, lx, ly, ones);
    draw_check(2, 6, 3, 3, 0, fx, fy, lx, ly, ones);
  endtask
  task automatic test_invalid();
    int hi;
    hi = 0;
    cell_row = 9; cell_col = 4'($urandom_range(0, 8)); cell_data = 3; start_write = 1;
    repeat (20) begin @(negedge clk); if (working !== 1'b0) hi++; end
    cell_row = 4'($urandom_range(0, 8)); cell_col = 4'($urandom_range(9, 15));
    repeat (20) begin @(negedge clk); if (working !== 1'b0) hi++; end
    start_write = 0;
    @(negedge clk);
    checks++;
    if (hi != 0) begin errors++; $display("FAIL invalid_start: working high %0d cycles expected 0", hi); end
  endtask
  task automatic test_reset_mid();
    int fx, fy, lx, ly, ones;
    cell_row = 3; cell_col = 4; cell_data = 7; start_write = 1;
    @(negedge clk);
    @(negedge clk);
    start_write = 0;
    repeat (1000) @(negedge clk);
    checks++;
    if (working !== 1'b1) begin errors++; $display("FAIL mid_draw: working=%b expected 1", working); end
    reset = 1;
    @(negedge clk);
    checks++;
    if (working !== 1'b0 || absolute_position !== 19'd0 || color_code !== 3'd0)
      begin errors++; $display("FAIL mid_reset: working=%b pos=%h colour=%0d expected 0 0 0", working, absolute_position, color_code); end
    reset = 0;
    @(negedge clk);
    draw_check(3, 4, 7, 5, 0, fx, fy, lx, ly, ones);
  endtask
  initial begin
    test_reset();
    test_start();
    test_corner();
    test_sweep();
    test_back_to_back();
    test_invalid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
